// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU sequencer: opcodes, FSM states, instruction fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Instruction word layout: [7:5] opcode, [4] destination, [3:0] imm/addr
  localparam int OPC_HI = 7;
  localparam int OPC_LO = 5;
  localparam int DST_BIT = 4;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LDI  = 3'b001,
    OP_MOV  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_AND  = 3'b101,
    OP_JZ   = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  function automatic opcode_t instr_op(input logic [7:0] ir);
    return opcode_t'(ir[OPC_HI:OPC_LO]);
  endfunction

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU for ADD/SUB/AND; any other opcode passes b through.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b - operands; op - opcode; result - 4-bit result; carry - ADD carry-out or SUB borrow.
module alu_4bit
  import cpu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  opcode_t    op,
  output logic [3:0] result,
  output logic       carry
);

  logic [4:0] sum5;
  logic [4:0] diff5;

  always_comb begin
    sum5   = {1'b0, a} + {1'b0, b};
    // Bit 4 of the 5-bit difference is set exactly when a < b (borrow)
    diff5  = {1'b0, a} - {1'b0, b};
    result = b;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum5[3:0];
        carry  = sum5[4];
      end
      OP_SUB: begin
        result = diff5[3:0];
        carry  = diff5[4];
      end
      OP_AND: begin
        result = a & b;
      end
      default: begin
        result = b;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving a 2x4-bit register file.
// Latency: 3 cycles for LDI/MOV/ALU, 2 for NOP/JZ, plus one per fetch wait cycle.
// Backpressure: holds instr_req and PC in FETCH until instr_ack; no other stalls.
// Ports: clk/reset (sync, active-high); instr_req/instr_addr/instr_ack/instr_data fetch port;
//        rf_we/rf_write_sel/rf_write_data write port, rf_read_sel/rf_read_data read port;
//        flag_zero/flag_carry status flags; halted after HALT.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned        PC_W     = 4,
  parameter logic [PC_W-1:0]    RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            instr_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic            instr_ack,
  input  logic [7:0]      instr_data,
  output logic            rf_we,
  output logic            rf_write_sel,
  output logic            rf_read_sel,
  output logic [3:0]      rf_write_data,
  input  logic [3:0]      rf_read_data,
  output logic            flag_zero,
  output logic            flag_carry,
  output logic            halted
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [3:0]      opa_q, opa_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;

  opcode_t         op;
  logic            dst;
  logic [3:0]      imm;
  logic [3:0]      alu_result;
  logic            alu_carry;
  logic [3:0]      exec_result;

  assign op  = instr_op(ir_q);
  assign dst = ir_q[DST_BIT];
  assign imm = ir_q[IMM_HI:IMM_LO];

  // Operand A is R0 latched in DECODE; operand B is whatever the read port shows in EXEC
  alu_4bit u_alu (
    .a      (opa_q),
    .b      (rf_read_data),
    .op     (op),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    opa_d         = opa_q;
    zero_d        = zero_q;
    carry_d       = carry_q;
    instr_req     = 1'b0;
    rf_we         = 1'b0;
    rf_write_sel  = 1'b0;
    rf_write_data = 4'd0;
    rf_read_sel   = 1'b0;
    exec_result   = (op == OP_LDI) ? imm : alu_result;

    case (state_q)
      FETCH: begin
        instr_req = 1'b1;
        if (instr_ack) begin
          ir_d    = instr_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        rf_read_sel = 1'b0;
        opa_d       = rf_read_data;
        case (op)
          OP_NOP:  state_d = FETCH;
          OP_JZ: begin
            if (zero_q) pc_d = PC_W'(imm);
            state_d = FETCH;
          end
          OP_HALT: state_d = HALTED;
          default: state_d = EXEC;
        endcase
      end
      EXEC: begin
        // MOV reads the other register; everything else reads R1 as operand B
        rf_read_sel   = (op == OP_MOV) ? ~dst : 1'b1;
        rf_we         = 1'b1;
        rf_write_sel  = dst;
        rf_write_data = exec_result;
        zero_d        = (exec_result == 4'd0);
        if (op == OP_ADD || op == OP_SUB) carry_d = alu_carry;
        state_d       = FETCH;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = FETCH;
    endcase

    // Reset masks every request/write strobe in the same cycle, so an EXEC
    // interrupted by reset never reaches the register file.
    if (reset) begin
      instr_req     = 1'b0;
      rf_we         = 1'b0;
      rf_write_sel  = 1'b0;
      rf_write_data = 4'd0;
      rf_read_sel   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'd0;
      opa_q   <= 4'd0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign instr_addr = pc_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign halted     = (state_q == HALTED) && !reset;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_req;
  logic [3:0] instr_addr;
  logic       instr_ack;
  logic [7:0] instr_data;
  logic       rf_we;
  logic       rf_write_sel;
  logic       rf_read_sel;
  logic [3:0] rf_write_data;
  logic [3:0] rf_read_data;
  logic       flag_zero;
  logic       flag_carry;
  logic       halted;

  int n_pass  = 0;
  int n_total = 0;

  // Architectural reference model (ISA level)
  int m_r [2];
  int m_pc;
  bit m_z, m_c, m_halt;

  always #5 clk = ~clk;

  control_unit #(.PC_W(4), .RESET_PC(4'd0)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_req     (instr_req),
    .instr_addr    (instr_addr),
    .instr_ack     (instr_ack),
    .instr_data    (instr_data),
    .rf_we         (rf_we),
    .rf_write_sel  (rf_write_sel),
    .rf_read_sel   (rf_read_sel),
    .rf_write_data (rf_write_data),
    .rf_read_data  (rf_read_data),
    .flag_zero     (flag_zero),
    .flag_carry    (flag_carry),
    .halted        (halted)
  );

  // Register file environment: written only by the DUT, cleared by the shared reset
  logic [3:0] rf [2];
  assign rf_read_data = rf[rf_read_sel];
  always @(posedge clk) begin
    if (reset) begin
      rf[0] <= 4'd0;
      rf[1] <= 4'd0;
    end else if (rf_we) begin
      rf[rf_write_sel] <= rf_write_data;
    end
  end

  task automatic model_reset();
    m_r[0] = 0; m_r[1] = 0; m_pc = 0; m_z = 0; m_c = 0; m_halt = 0;
  endtask

  task automatic model_step(input logic [7:0] ins, output bit wr, output logic [3:0] wval,
                            output logic wsel, output int exp_end);
    int op, d, imm, res;
    op = int'(ins[7:5]); d = int'(ins[4]); imm = int'(ins[3:0]);
    wr = 0; res = 0; wval = 0; wsel = 0;
    m_pc = (m_pc + 1) % 16;
    case (op)
      1: begin res = imm; wr = 1; end
      2: begin res = m_r[1 - d]; wr = 1; end
      3: begin res = m_r[0] + m_r[1]; m_c = (res > 15); res = res % 16; wr = 1; end
      4: begin m_c = (m_r[0] < m_r[1]); res = (m_r[0] - m_r[1] + 16) % 16; wr = 1; end
      5: begin res = m_r[0] & m_r[1]; wr = 1; end
      6: if (m_z) m_pc = imm;
      7: m_halt = 1;
      default: ;
    endcase
    if (wr) begin
      m_r[d] = res;
      m_z = (res == 0);
      wsel = d[0];
      wval = res[3:0];
    end
    // Negedges after the ack cycle until FETCH (or HALTED) becomes visible
    exp_end = wr ? 3 : 2;
  endtask

  // Fetch and retire one instruction, scoreboarding timing, writes and architectural state
  task automatic exec_one(input logic [7:0] ins, input int waits, input bit noisy);
    int n, we_at, end_at, exp_end;
    bit ew;
    logic [3:0] ev;
    logic es;
    n = 0;
    while (instr_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_total++;
    if (instr_req !== 1'b1) $display("FAIL req_timeout: instr_req=%b want 1", instr_req);
    else n_pass++;
    n_total++;
    if (instr_addr !== m_pc[3:0]) $display("FAIL fetch_addr: got %0h want %0h", instr_addr, m_pc[3:0]);
    else n_pass++;
    for (int w = 0; w < waits; w++) begin
      instr_ack = 1'b0; instr_data = 8'($urandom);
      @(negedge clk);
      n_total++;
      if ({instr_req, instr_addr, rf_we} !== {1'b1, m_pc[3:0], 1'b0})
        $display("FAIL fetch_hold: req=%b addr=%0h we=%b want 1 %0h 0", instr_req, instr_addr, rf_we, m_pc[3:0]);
      else n_pass++;
    end
    instr_ack = 1'b1; instr_data = ins;
    model_step(ins, ew, ev, es, exp_end);
    @(negedge clk);
    we_at = 0; end_at = 0;
    for (int k = 1; k <= 4 && end_at == 0; k++) begin
      if (instr_req === 1'b1 || halted === 1'b1) begin
        end_at = k;
        instr_ack = 1'b0;
      end else begin
        if (noisy) begin instr_ack = 1'($urandom_range(0, 1)); instr_data = 8'($urandom); end
        else instr_ack = 1'b0;
        if (rf_we === 1'b1) begin
          we_at = k;
          n_total++;
          if ({rf_write_sel, rf_write_data} !== {es, ev})
            $display("FAIL write_port ins=%02h: sel=%b data=%0h want %b %0h", ins, rf_write_sel, rf_write_data, es, ev);
          else n_pass++;
        end
        @(negedge clk);
      end
    end
    n_total++;
    if (we_at != (ew ? 2 : 0) || end_at != exp_end)
      $display("FAIL timing ins=%02h: we_at=%0d end_at=%0d want %0d %0d", ins, we_at, end_at, ew ? 2 : 0, exp_end);
    else n_pass++;
    n_total++;
    if ({rf[0], rf[1]} !== {m_r[0][3:0], m_r[1][3:0]})
      $display("FAIL regs ins=%02h: R0=%0h R1=%0h want %0h %0h", ins, rf[0], rf[1], m_r[0][3:0], m_r[1][3:0]);
    else n_pass++;
    n_total++;
    if ({flag_zero, flag_carry, halted} !== {m_z, m_c, m_halt})
      $display("FAIL flags ins=%02h: z=%b c=%b h=%b want %b %b %b", ins, flag_zero, flag_carry, halted, m_z, m_c, m_halt);
    else n_pass++;
    if (!m_halt) begin
      n_total++;
      if (instr_addr !== m_pc[3:0]) $display("FAIL next_pc ins=%02h: got %0h want %0h", ins, instr_addr, m_pc[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_ack = 1'b1; instr_data = 8'h3F;
    repeat (3) @(negedge clk);
    n_total++;
    if ({instr_req, rf_we, rf_write_sel, rf_write_data, rf_read_sel} !== 8'd0)
      $display("FAIL reset_outputs: req=%b we=%b ws=%b wd=%0h rs=%b want all 0", instr_req, rf_we, rf_write_sel, rf_write_data, rf_read_sel);
    else n_pass++;
    n_total++;
    if ({flag_zero, flag_carry, halted} !== 3'b000)
      $display("FAIL reset_flags: z=%b c=%b h=%b want 0 0 0", flag_zero, flag_carry, halted);
    else n_pass++;
    reset = 1'b0; instr_ack = 1'b0;
    model_reset();
    @(negedge clk);
    n_total++;
    if ({instr_req, instr_addr} !== {1'b1, 4'h0})
      $display("FAIL reset_fetch: req=%b addr=%0h want 1 0", instr_req, instr_addr);
    else n_pass++;
  endtask

  task automatic test_fetch_wait();
    exec_one(8'h25, 3, 1'b0);
    n_total++;
    if (rf[0] !== 4'd5) $display("FAIL ldi_r0: got %0h want 5", rf[0]);
    else n_pass++;
  endtask

  task automatic test_arith();
    exec_one(8'h29, $urandom_range(0, 2), 1'b0);
    exec_one(8'h38, $urandom_range(0, 2), 1'b0);
    exec_one(8'h60, $urandom_range(0, 2), 1'b0);
    n_total++;
    if ({rf[0], flag_carry, flag_zero} !== {4'd1, 1'b1, 1'b0})
      $display("FAIL add_9_8: R0=%0h c=%b z=%b want 1 1 0", rf[0], flag_carry, flag_zero);
    else n_pass++;
    exec_one(8'h90, $urandom_range(0, 2), 1'b0);
    n_total++;
    if ({rf[1], flag_carry} !== {4'd9, 1'b1})
      $display("FAIL sub_1_8: R1=%0h c=%b want 9 1", rf[1], flag_carry);
    else n_pass++;
  endtask

  task automatic test_zero_jump();
    exec_one(8'h23, 0, 1'b0);
    exec_one(8'h33, 0, 1'b0);
    exec_one(8'h80, 0, 1'b0);
    n_total++;
    if ({rf[0], flag_zero} !== {4'd0, 1'b1})
      $display("FAIL sub_zero: R0=%0h z=%b want 0 1", rf[0], flag_zero);
    else n_pass++;
    exec_one(8'hCA, 1, 1'b0);
    n_total++;
    if (instr_addr !== 4'hA) $display("FAIL jz_taken: addr=%0h want a", instr_addr);
    else n_pass++;
    exec_one(8'h21, 0, 1'b0);
    exec_one(8'hCA, 0, 1'b0);
    n_total++;
    if (instr_addr !== 4'hC) $display("FAIL jz_fallthrough: addr=%0h want c", instr_addr);
    else n_pass++;
  endtask

  task automatic test_mov_and();
    exec_one(8'h2F, 0, 1'b0);
    exec_one(8'h31, 0, 1'b0);
    exec_one(8'h60, 0, 1'b0);
    exec_one(8'h2C, 0, 1'b0);
    exec_one(8'h36, 0, 1'b0);
    exec_one(8'h50, 1, 1'b0);
    n_total++;
    if (rf[1] !== 4'hC) $display("FAIL mov_r1: got %0h want c", rf[1]);
    else n_pass++;
    exec_one(8'hA0, 0, 1'b0);
    n_total++;
    if ({rf[0], flag_carry} !== {4'hC, 1'b1})
      $display("FAIL and_r0: R0=%0h c=%b want c 1", rf[0], flag_carry);
    else n_pass++;
  endtask

  task automatic test_wrap_halt();
    exec_one(8'h20, 0, 1'b0);
    exec_one(8'hCF, 0, 1'b0);
    n_total++;
    if (instr_addr !== 4'hF) $display("FAIL jump_to_15: addr=%0h want f", instr_addr);
    else n_pass++;
    exec_one(8'h00, 0, 1'b0);
    n_total++;
    if (instr_addr !== 4'h0) $display("FAIL pc_wrap: addr=%0h want 0", instr_addr);
    else n_pass++;
    exec_one(8'hE0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      instr_ack = 1'($urandom_range(0, 1)); instr_data = 8'($urandom);
      @(negedge clk);
      n_total++;
      if ({halted, instr_req, rf_we} !== 3'b100)
        $display("FAIL halt_hold: h=%b req=%b we=%b want 1 0 0", halted, instr_req, rf_we);
      else n_pass++;
    end
    reset = 1'b1; instr_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_total++;
    if ({halted, instr_req, instr_addr} !== {1'b0, 1'b1, 4'h0})
      $display("FAIL halt_reset: h=%b req=%b addr=%0h want 0 1 0", halted, instr_req, instr_addr);
    else n_pass++;
  endtask

  task automatic test_reset_exec();
    int n;
    n = 0;
    while (instr_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    instr_ack = 1'b1; instr_data = 8'h37;
    @(negedge clk);
    instr_ack = 1'b0;
    @(negedge clk);
    n_total++;
    if (rf_we !== 1'b1) $display("FAIL exec_reached: we=%b want 1", rf_we);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({rf_we, rf_write_data} !== 5'd0)
      $display("FAIL reset_in_exec: we=%b data=%0h want 0 0", rf_we, rf_write_data);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({rf[1], instr_req, instr_addr} !== {4'd0, 1'b1, 4'h0})
      $display("FAIL reset_exec_after: R1=%0h req=%b addr=%0h want 0 1 0", rf[1], instr_req, instr_addr);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] ins;
    for (int i = 0; i < 60; i++) begin
      ins = 8'($urandom);
      if (ins[7:5] == 3'b111) ins[7:5] = 3'b000;
      exec_one(ins, $urandom_range(0, 2), 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; instr_ack = 1'b0; instr_data = 8'h00;
    model_reset();
    test_reset();
    test_fetch_wait();
    test_arith();
    test_zero_jump();
    test_mov_and();
    test_wrap_halt();
    test_reset_exec();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
